// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared constants and types for the CORDIC scheduler
// Contents:
//   ADDR_X/ADDR_Y/ADDR_Z/ADDR_GO : peripheral register addresses
//   TIMEOUT_DEFAULT              : default cycle budget spent waiting for done
//   state_t                      : scheduler FSM state encoding
//   next_ptr()                   : round-robin pointer advance, wraps at nreq
package cordic_pkg;

  localparam int ADDR_W = 6;
  localparam int ID_W   = 3;

  localparam logic [ADDR_W-1:0] ADDR_X  = 6'd0;
  localparam logic [ADDR_W-1:0] ADDR_Y  = 6'd1;
  localparam logic [ADDR_W-1:0] ADDR_Z  = 6'd2;
  localparam logic [ADDR_W-1:0] ADDR_GO = 6'd3;

  localparam int TIMEOUT_DEFAULT = 64;

  typedef enum logic [2:0] {
    IDLE,
    WR_X,
    WR_Y,
    WR_Z,
    WR_GO,
    WAIT,
    RESP
  } state_t;

  // The next service round starts searching one past the requester just served.
  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id, input int nreq);
    return (int'(id) == nreq - 1) ? '0 : id + 1'b1;
  endfunction

endpackage

// File: rtl/cordic_sched_if.sv
// rtl/cordic_sched_if.sv - requester, response and peripheral bus signals
// Signals:
//   req_valid/req_ready      : per-requester pending flag / one-hot accept pulse
//   req_x/req_y/req_z        : packed operands, requester i in bits 32i+31:32i
//   rsp_valid/rsp_id         : one-cycle result strobe / owning requester
//   rsp_data/rsp_err         : result word / timeout flag
//   bus_wr/bus_addr          : peripheral write strobe / register address
//   bus_data_in              : peripheral write data
//   bus_data_out/cordic_done : peripheral result / completion flag
// Modports: master = scheduler side, slave = requesters plus peripheral.
interface cordic_sched_if
  import cordic_pkg::*;
#(
  parameter int NREQ = 2
);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [32*NREQ-1:0]   req_x;
  logic [32*NREQ-1:0]   req_y;
  logic [32*NREQ-1:0]   req_z;

  logic                 rsp_valid;
  logic [ID_W-1:0]      rsp_id;
  logic [31:0]          rsp_data;
  logic                 rsp_err;

  logic [31:0]          bus_data_in;
  logic [ADDR_W-1:0]    bus_addr;
  logic                 bus_wr;
  logic [31:0]          bus_data_out;
  logic                 cordic_done;

  modport master (
    input  req_valid, req_x, req_y, req_z, bus_data_out, cordic_done,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
           bus_data_in, bus_addr, bus_wr
  );

  modport slave (
    output req_valid, req_x, req_y, req_z, bus_data_out, cordic_done,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
           bus_data_in, bus_addr, bus_wr
  );

endinterface

// File: rtl/cordic_sched_rr_arbiter.sv
// rtl/cordic_sched_rr_arbiter.sv - combinational round-robin grant
// Ports:
//   req   in  NREQ : pending requesters
//   ptr   in  3    : highest-priority requester index for this round
//   gnt   out NREQ : one-hot grant (all zero when nothing is pending)
//   idx   out 3    : index of the granted requester
//   found out 1    : at least one requester is pending
module rr_arbiter
  import cordic_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] idx,
  output logic            found
);

  int cand;

  // Walk the requesters starting at ptr and wrapping; first pending one wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/cordic_sched.sv
// rtl/cordic_sched.sv - shares one CORDIC peripheral among NREQ requesters
// Ports:
//   clk : single clock, rising edge
//   rst : synchronous active-high reset
//   sif : cordic_sched_if.master (requests, responses, peripheral bus)
// Each service: accept pulse, four bus writes (X, Y, Z, start), wait for
// done or timeout, one response strobe, then one idle cycle.
module cordic_sched
  import cordic_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  cordic_sched_if.master sif
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   id;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       y_q;
  logic [31:0]       z_q;

  logic [NREQ-1:0]   ready_q;
  logic              rsp_valid_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [31:0]       rsp_data_q;
  logic              rsp_err_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [NREQ-1:0]   gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              any_req;

  function automatic logic [31:0] lane(input logic [32*NREQ-1:0] v, input logic [ID_W-1:0] i);
    return v[32*int'(i) +: 32];
  endfunction

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req   (sif.req_valid),
    .ptr   (ptr),
    .gnt   (gnt),
    .idx   (gnt_idx),
    .found (any_req)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      id          <= '0;
      cnt         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      ready_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      // Strobes and bus drive default low; only write states raise the bus.
      ready_q     <= '0;
      rsp_valid_q <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;

      case (state)
        IDLE: begin
          if (|ready_q) begin
            // Accept cycle: operands are taken now, X goes out immediately.
            wr_q    <= 1'b1;
            addr_q  <= ADDR_X;
            wdata_q <= lane(sif.req_x, id);
            y_q     <= lane(sif.req_y, id);
            z_q     <= lane(sif.req_z, id);
            state   <= WR_X;
          end else if (any_req) begin
            ready_q <= gnt;
            id      <= gnt_idx;
          end
        end
        WR_X: begin
          wr_q    <= 1'b1;
          addr_q  <= ADDR_Y;
          wdata_q <= y_q;
          state   <= WR_Y;
        end
        WR_Y: begin
          wr_q    <= 1'b1;
          addr_q  <= ADDR_Z;
          wdata_q <= z_q;
          state   <= WR_Z;
        end
        WR_Z: begin
          wr_q    <= 1'b1;
          addr_q  <= ADDR_GO;
          wdata_q <= 32'd1;
          state   <= WR_GO;
        end
        WR_GO: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          // done is tested first so it wins over a coinciding timeout
          if (sif.cordic_done) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id;
            rsp_data_q  <= sif.bus_data_out;
            rsp_err_q   <= 1'b0;
            state       <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          ptr   <= next_ptr(id, NREQ);
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign sif.req_ready   = ready_q;
  assign sif.rsp_valid   = rsp_valid_q;
  assign sif.rsp_id      = rsp_id_q;
  assign sif.rsp_data    = rsp_data_q;
  assign sif.rsp_err     = rsp_err_q;
  assign sif.bus_wr      = wr_q;
  assign sif.bus_addr    = addr_q;
  assign sif.bus_data_in = wdata_q;

endmodule

// File: tb/tb_cordic_sched.sv
// tb/tb_cordic_sched.sv - randomized self-checking bench for cordic_sched
module tb_cordic_sched;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  cordic_sched_if #(.NREQ(NREQ)) sif ();

  cordic_sched #(
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif.master)
  );

  int errors = 0;
  int checks = 0;
  int rr_model = 0;

  logic [31:0] opx [NREQ];
  logic [31:0] opy [NREQ];
  logic [31:0] opz [NREQ];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference arbitration: first pending requester at or after the pointer.
  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return 0;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < NREQ; i++) begin
      sif.req_x[32*i +: 32] = opx[i];
      sif.req_y[32*i +: 32] = opy[i];
      sif.req_z[32*i +: 32] = opz[i];
    end
  endtask

  task automatic random_ops();
    for (int i = 0; i < NREQ; i++) begin
      opx[i] = $urandom;
      opy[i] = $urandom;
      opz[i] = $urandom;
    end
    drive_ops();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sif.req_valid = '0;
    sif.cordic_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rr_model = 0;
  endtask

  // One full service. done_n = cycles after the start write at which the
  // peripheral raises done (<1 means never). Expected timing: response one
  // cycle after done, or TIMEOUT+1 cycles after start when done is absent
  // or later than the last waiting cycle.
  task automatic run_op(input logic [NREQ-1:0] valid, input int done_n, input bit tog);
    int exp_id;
    int waited;
    int resp_t;
    int bad_rdy;
    int bad_rsp;
    int bad_bus;
    logic [31:0] ex [4];
    logic [31:0] exp_data;
    logic        exp_err;

    bad_rdy = 0;
    bad_rsp = 0;
    bad_bus = 0;
    sif.req_valid = valid;
    exp_id = pick(valid, rr_model);
    ex[0] = opx[exp_id];
    ex[1] = opy[exp_id];
    ex[2] = opz[exp_id];
    ex[3] = 32'd1;

    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (sif.req_ready == '0 && waited < 8);
    check_eq("req_ready", 32'(sif.req_ready), 32'(1) << exp_id);

    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      check_eq("bus_wr", 32'(sif.bus_wr), 32'd1);
      check_eq("bus_addr", 32'(sif.bus_addr), 32'(w));
      check_eq("bus_data_in", sif.bus_data_in, ex[w]);
      bad_rdy += int'(sif.req_ready != '0);
      if (w == 0) random_ops();
    end

    exp_err  = !(done_n >= 1 && done_n <= TIMEOUT);
    resp_t   = exp_err ? TIMEOUT + 1 : done_n + 1;
    exp_data = '0;
    for (int t = 1; t <= resp_t; t++) begin
      @(negedge clk);
      if (t == resp_t) begin
        check_eq("rsp_valid", 32'(sif.rsp_valid), 32'd1);
        check_eq("rsp_id", 32'(sif.rsp_id), 32'(exp_id));
        check_eq("rsp_data", sif.rsp_data, exp_data);
        check_eq("rsp_err", 32'(sif.rsp_err), 32'(exp_err));
        sif.cordic_done = 1'b0;
        sif.req_valid = valid;
      end else begin
        bad_rsp += int'(sif.rsp_valid);
        bad_bus += int'(sif.bus_wr || sif.bus_addr != '0 || sif.bus_data_in != '0);
        bad_rdy += int'(sif.req_ready != '0);
        sif.bus_data_out = $urandom;
        sif.cordic_done = (t == done_n);
        if (t == done_n) exp_data = sif.bus_data_out;
        if (tog) sif.req_valid = NREQ'($urandom);
      end
    end

    @(negedge clk);
    check_eq("rsp_pulse", 32'(sif.rsp_valid), 32'd0);
    check_eq("rsp_hold", sif.rsp_data, exp_data);
    check_eq("idle_gap", 32'(sif.req_ready), 32'd0);
    check_eq("extra_ready", 32'(bad_rdy), 32'd0);
    check_eq("early_rsp", 32'(bad_rsp), 32'd0);
    check_eq("bus_quiet", 32'(bad_bus), 32'd0);
    rr_model = (exp_id + 1) % NREQ;
  endtask

  task automatic reset_mid_op();
    int n;
    int found;
    int rsp_seen;
    int rdy_seen;
    random_ops();
    sif.req_valid = '1;
    found = 0;
    n = 0;
    while (!found && n < 12) begin
      @(negedge clk);
      n++;
      if (sif.bus_wr && sif.bus_addr == 6'd1) found = 1;
    end
    check_eq("seen_wr_y", 32'(found), 32'd1);
    rst = 1'b1;
    sif.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_bus_wr", 32'(sif.bus_wr), 32'd0);
    rsp_seen = 0;
    rdy_seen = 0;
    for (int i = 0; i < TIMEOUT + 16; i++) begin
      @(negedge clk);
      rsp_seen += int'(sif.rsp_valid);
      rdy_seen += int'(sif.req_ready != '0);
    end
    check_eq("rst_no_rsp", 32'(rsp_seen), 32'd0);
    check_eq("rst_no_ready", 32'(rdy_seen), 32'd0);
    rr_model = 0;
    random_ops();
    run_op('1, 10, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    sif.req_valid    = '0;
    sif.req_x        = '0;
    sif.req_y        = '0;
    sif.req_z        = '0;
    sif.bus_data_out = '0;
    sif.cordic_done  = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", 32'(sif.req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(sif.rsp_valid), 32'd0);
    check_eq("rst_rsp_id", 32'(sif.rsp_id), 32'd0);
    check_eq("rst_rsp_data", sif.rsp_data, 32'd0);
    check_eq("rst_rsp_err", 32'(sif.rsp_err), 32'd0);
    check_eq("rst_bus_wr0", 32'(sif.bus_wr), 32'd0);
    check_eq("rst_bus_addr", 32'(sif.bus_addr), 32'd0);
    check_eq("rst_bus_data", sif.bus_data_in, 32'd0);
    rst = 1'b0;
    rr_model = 0;

    // Directed single operation from requester 0.
    random_ops();
    opx[0] = 32'd1;
    opy[0] = 32'd5;
    opz[0] = 32'd157079;
    drive_ops();
    run_op(2'b01, 20, 1'b0);

    // Both requesters held: alternating grants from a fresh pointer.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      random_ops();
      run_op(2'b11, int'($urandom_range(1, 30)), 1'b0);
    end

    // Timeout, done on the last waiting cycle, done just too late.
    random_ops();
    run_op(2'b10, 0, 1'b0);
    random_ops();
    run_op(2'b11, TIMEOUT, 1'b0);
    random_ops();
    run_op(2'b11, TIMEOUT + 1, 1'b0);

    // req_valid toggling while waiting.
    random_ops();
    run_op(2'b11, 15, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 20; i++) begin
      random_ops();
      run_op(NREQ'($urandom_range(1, (1 << NREQ) - 1)),
             int'($urandom_range(0, TIMEOUT + 4)),
             1'($urandom));
    end

    // Reset during WR_Y with the pointer pointing at requester 1.
    random_ops();
    run_op(2'b01, 5, 1'b0);
    reset_mid_op();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
